// File: rtl/riscv_dmem_responder.sv
// Data-memory responder: one outstanding word request, fixed WAIT_CYCLES latency, byte-enabled writes.
// Optional alignment/byte-select checking is enabled with `define RISCV_DMEM_ALIGN_CHECK_EN.
module riscv_dmem_responder #(
  parameter int XLEN          = 32,
  parameter int DMEM_ADDR_BIT = 12,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic            i_req_wen,
  input  logic [XLEN-1:0] i_req_wr_data,
  input  logic [3:0]      i_req_byte_sel,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_rd_data,
  output logic            o_rsp_err,
  output logic            o_busy,
  output logic [1:0]      o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // Request side is ready only in IDLE; response side holds valid and its payload stable
  // until i_rsp_ready is seen, and the responder never withdraws a pending response.

  localparam int IW    = DMEM_ADDR_BIT - 2;
  localparam int DEPTH = 1 << IW;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q;
  logic            wen_q;
  logic [XLEN-1:0] wdata_q;
  logic [3:0]      bsel_q;
  logic [XLEN-1:0] rd_data_q;
  logic            err_q;
  logic [XLEN-1:0] mem [DEPTH];

  logic            accept;
  logic            do_access;
  logic [IW-1:0]   acc_idx;
  logic            acc_wen;
  logic [XLEN-1:0] acc_wdata;
  logic [3:0]      acc_bsel;
  logic            acc_err;

  assign accept = (state_q == S_IDLE) && i_req_valid;

  // With zero wait states the access happens on the accepting edge, so use the live request.
  assign acc_idx   = (state_q == S_IDLE) ? i_req_addr[DMEM_ADDR_BIT-1:2] : idx_q;
  assign acc_wen   = (state_q == S_IDLE) ? i_req_wen : wen_q;
  assign acc_wdata = (state_q == S_IDLE) ? i_req_wr_data : wdata_q;
  assign acc_bsel  = (state_q == S_IDLE) ? i_req_byte_sel : bsel_q;

`ifdef RISCV_DMEM_ALIGN_CHECK_EN
  logic [1:0] lane_q;
  logic [1:0] acc_lane;
  logic       unused_addr_bits;

  assign acc_lane         = (state_q == S_IDLE) ? i_req_addr[1:0] : lane_q;
  assign unused_addr_bits = ^i_req_addr[XLEN-1:DMEM_ADDR_BIT];

  always_ff @(posedge i_clk) begin
    if (accept) lane_q <= i_req_addr[1:0];
  end

  // Legal selects are naturally aligned byte, halfword and word; lowest lane must match addr[1:0].
  always_comb begin
    acc_err = 1'b1;
    case (acc_bsel)
      4'b0001, 4'b0011, 4'b1111: acc_err = (acc_lane != 2'd0);
      4'b0010:                   acc_err = (acc_lane != 2'd1);
      4'b0100, 4'b1100:          acc_err = (acc_lane != 2'd2);
      4'b1000:                   acc_err = (acc_lane != 2'd3);
      default:                   acc_err = 1'b1;
    endcase
  end
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_req_addr[XLEN-1:DMEM_ADDR_BIT], i_req_addr[1:0]};
  assign acc_err          = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    o_req_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (i_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory is touched only on the edge that enters RESP, and never while reset is asserted.
  assign do_access = (state_d == S_RESP) && (state_q != S_RESP) && !i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (do_access) begin
        rd_data_q <= (acc_wen || acc_err) ? '0 : mem[acc_idx];
        err_q     <= acc_err;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      idx_q   <= i_req_addr[DMEM_ADDR_BIT-1:2];
      wen_q   <= i_req_wen;
      wdata_q <= i_req_wr_data;
      bsel_q  <= i_req_byte_sel;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_access && acc_wen && !acc_err) begin
      for (int n = 0; n < 4; n++) begin
        if (acc_bsel[n]) mem[acc_idx][8*n +: 8] <= acc_wdata[8*n +: 8];
      end
    end
  end

  assign o_rsp_valid   = (state_q == S_RESP);
  assign o_busy        = (state_q != S_IDLE);
  assign o_rsp_rd_data = rd_data_q;
  assign o_rsp_err     = err_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Bench for riscv_dmem_responder: two instances (WAIT_CYCLES=2 and 0) checked against a word-array
// model with byte-lane writes; honours RISCV_DMEM_ALIGN_CHECK_EN in its error model.
module tb_riscv_dmem_responder;

  localparam int W_A = 2;
  localparam int W_B = 0;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic        req_wen   [2];
  logic [31:0] wr_data   [2];
  logic [3:0]  bsel      [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rd_data   [2];
  logic        rsp_err   [2];
  logic        busy      [2];
  logic [1:0]  dbg_state [2];

  logic [31:0] model [2][1024];
  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  riscv_dmem_responder #(.XLEN(32), .DMEM_ADDR_BIT(12), .WAIT_CYCLES(W_A)) dut_a (
    .i_clk(clk), .i_rst(rst[0]), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_addr(req_addr[0]), .i_req_wen(req_wen[0]), .i_req_wr_data(wr_data[0]),
    .i_req_byte_sel(bsel[0]), .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
    .o_rsp_rd_data(rd_data[0]), .o_rsp_err(rsp_err[0]), .o_busy(busy[0]),
    .o_dbg_state(dbg_state[0])
  );

  riscv_dmem_responder #(.XLEN(32), .DMEM_ADDR_BIT(12), .WAIT_CYCLES(W_B)) dut_b (
    .i_clk(clk), .i_rst(rst[1]), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_addr(req_addr[1]), .i_req_wen(req_wen[1]), .i_req_wr_data(wr_data[1]),
    .i_req_byte_sel(bsel[1]), .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
    .o_rsp_rd_data(rd_data[1]), .o_rsp_err(rsp_err[1]), .o_busy(busy[1]),
    .o_dbg_state(dbg_state[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input int u);
    return (u == 0) ? W_A : W_B;
  endfunction

  // Reference: an access errs only when checking is built in and the select is not a naturally
  // aligned byte/half/word whose lowest lane equals addr[1:0].
  function automatic logic model_err(input logic [31:0] a, input logic [3:0] bs);
`ifdef RISCV_DMEM_ALIGN_CHECK_EN
    int low;
    if (!(bs inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111})) return 1'b1;
    low = 0;
    while (!bs[low]) low++;
    return (low != int'(a[1:0]));
`else
    return (a === 32'hx) && (bs === 4'hx);
`endif
  endfunction

  task automatic model_apply(input int u, input logic [31:0] a, input logic wen,
                             input logic [31:0] d, input logic [3:0] bs, output logic e);
    int w;
    w = int'(a % 4096) / 4;
    e = model_err(a, bs);
    if (e || wen) begin
      exp_q.push_back(32'h0);
      if (wen && !e)
        for (int n = 0; n < 4; n++)
          if (bs[n]) model[u][w][8*n +: 8] = d[8*n +: 8];
    end else begin
      exp_q.push_back(model[u][w]);
    end
  endtask

  task automatic drive_req(input int u, input logic [31:0] a, input logic wen,
                           input logic [31:0] d, input logic [3:0] bs);
    req_valid[u] = 1'b1;
    req_addr[u]  = a;
    req_wen[u]   = wen;
    wr_data[u]   = d;
    bsel[u]      = bs;
  endtask

  // Wait for the response, measuring edges after the accepting edge; bounded.
  task automatic wait_rsp(input int u, output int cyc);
    cyc = 0;
    while (rsp_valid[u] !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic do_txn(input int u, input logic [31:0] a, input logic wen, input logic [31:0] d,
                        input logic [3:0] bs, input int hold, input bit poke);
    logic e;
    int cyc;
    logic [31:0] exp_rd;
    model_apply(u, a, wen, d, bs, e);
    exp_rd = exp_q.pop_front();
    drive_req(u, a, wen, d, bs);
    chk("req_ready_idle", 32'(req_ready[u]), 32'd1);
    @(posedge clk); #1;
    req_valid[u] = 1'b0;
    wait_rsp(u, cyc);
    chk("latency", cyc, lat(u));
    chk("rd_data", rd_data[u], exp_rd);
    chk("rsp_err", 32'(rsp_err[u]), 32'(e));
    for (int i = 0; i < hold; i++) begin
      if (poke) drive_req(u, a ^ 32'h40, 1'b1, $urandom, 4'hF);
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid[u]), 32'd1);
      chk("hold_data", rd_data[u], exp_rd);
      chk("hold_busy", 32'(busy[u]), 32'd1);
      chk("hold_ready", 32'(req_ready[u]), 32'd0);
    end
    req_valid[u] = 1'b0;
    rsp_ready[u] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[u] = 1'b0;
    chk("post_valid", 32'(rsp_valid[u]), 32'd0);
    chk("post_busy", 32'(busy[u]), 32'd0);
    chk("post_ready", 32'(req_ready[u]), 32'd1);
  endtask

  task automatic pulse_reset(input int u);
    rst[u] = 1'b1;
    @(posedge clk); #1;
    rst[u] = 1'b0;
    req_valid[u] = 1'b0;
    chk("rst_valid", 32'(rsp_valid[u]), 32'd0);
    chk("rst_busy", 32'(busy[u]), 32'd0);
    chk("rst_ready", 32'(req_ready[u]), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic e;
    logic [31:0] a;
    logic [3:0] bs_tab [8];
    bs_tab = '{4'b1111, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b0101};
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; req_valid[u] = 1'b0; req_addr[u] = '0; req_wen[u] = 1'b0;
      wr_data[u] = '0; bsel[u] = '0; rsp_ready[u] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("reset_valid", 32'(rsp_valid[u]), 32'd0);
      chk("reset_rd", rd_data[u], 32'd0);
      chk("reset_err", 32'(rsp_err[u]), 32'd0);
      chk("reset_busy", 32'(busy[u]), 32'd0);
      chk("reset_ready", 32'(req_ready[u]), 32'd1);
      rst[u] = 1'b0;
    end

    // Give words 0..15 of both instances known contents.
    for (int u = 0; u < 2; u++)
      for (int w = 0; w < 16; w++)
        do_txn(u, 32'(w * 4), 1'b1, $urandom, 4'hF, 0, 1'b0);

    // Full write then read; lane write; empty-select write.
    do_txn(0, 32'h10, 1'b1, 32'hDEADBEEF, 4'b1111, 0, 1'b0);
    do_txn(0, 32'h10, 1'b0, 32'h0, 4'b1111, 0, 1'b0);
    do_txn(0, 32'h11, 1'b1, 32'h0000AA00, 4'b0010, 0, 1'b0);
    do_txn(0, 32'h10, 1'b0, 32'h0, 4'b1111, 0, 1'b0);
    chk("lane_merge", model[0][4], 32'hDEADAAEF);
    do_txn(0, 32'h10, 1'b1, 32'hFFFFFFFF, 4'b0000, 0, 1'b0);
    do_txn(0, 32'h10, 1'b0, 32'h0, 4'b1111, 0, 1'b0);

    // Backpressure with a competing request that must not be queued.
    do_txn(0, 32'h10, 1'b0, 32'h0, 4'b1111, 5, 1'b1);
    do_txn(0, 32'h50, 1'b0, 32'h0, 4'b1111, 0, 1'b0);

    // Zero wait states and address aliasing.
    do_txn(1, 32'h1010, 1'b1, 32'h12345678, 4'b1111, 0, 1'b0);
    do_txn(1, 32'h010, 1'b0, 32'h0, 4'b1111, 0, 1'b0);

    // Reset while waiting aborts the write.
    do_txn(0, 32'h20, 1'b1, 32'hDEADBEEF, 4'b1111, 0, 1'b0);
    drive_req(0, 32'h20, 1'b1, 32'h55555555, 4'b1111);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("wait_busy", 32'(busy[0]), 32'd1);
    pulse_reset(0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("abort_no_rsp", 32'(rsp_valid[0]), 32'd0);
    end
    do_txn(0, 32'h20, 1'b0, 32'h0, 4'b1111, 0, 1'b0);

    // Reset on the accepting edge drops the request (zero-wait instance would otherwise write).
    drive_req(1, 32'h24, 1'b1, 32'h0BADF00D, 4'b1111);
    pulse_reset(1);
    do_txn(1, 32'h24, 1'b0, 32'h0, 4'b1111, 0, 1'b0);

    // Reset in RESP drops the response but the write has landed.
    model_apply(0, 32'h28, 1'b1, 32'hCAFEF00D, 4'b1111, e);
    void'(exp_q.pop_front());
    drive_req(0, 32'h28, 1'b1, 32'hCAFEF00D, 4'b1111);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp(0, cyc);
    chk("resp_before_rst", 32'(rsp_valid[0]), 32'd1);
    pulse_reset(0);
    do_txn(0, 32'h28, 1'b0, 32'h0, 4'b1111, 0, 1'b0);

    // Misaligned word write and aligned upper-half write.
    do_txn(0, 32'h12, 1'b1, 32'hA5A5A5A5, 4'b1111, 0, 1'b0);
    do_txn(0, 32'h10, 1'b0, 32'h0, 4'b1111, 0, 1'b0);
    do_txn(0, 32'h12, 1'b1, 32'h7E7E0000, 4'b1100, 0, 1'b0);
    do_txn(0, 32'h10, 1'b0, 32'h0, 4'b1111, 0, 1'b0);

    // Randomized traffic over the known words with aliased upper address bits.
    for (int k = 0; k < 120; k++) begin
      int u;
      u = k % 2;
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      do_txn(u, a, 1'($urandom_range(0, 1)), $urandom, bs_tab[$urandom_range(0, 7)],
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
